// File: rtl/module_reg_f_pkg.sv
// Shared datapath definitions: data width, register bus-select codes and
// the control-unit opcode set that drives the BusOut select lines.
package module_reg_f_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;

    // Bus-select codes placed on BusOut by the control unit; one per datapath register
    typedef enum logic [7:0] {
        BUS_NONE  = 8'd0,
        BUS_PC    = 8'd10,
        BUS_IR    = 8'd11,
        BUS_ACC   = 8'd12,
        BUS_REG_B = 8'd16,
        BUS_REG_C = 8'd17,
        BUS_REG_D = 8'd18,
        BUS_REG_E = 8'd19,
        BUS_REG_F = 8'd20,
        BUS_REG_G = 8'd21,
        BUS_REG_H = 8'd22,
        BUS_MDR   = 8'd23,
        BUS_MAR   = 8'd24
    } bus_id_e;

    localparam logic [7:0] REG_F_ID = 8'd20;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LOAD = 4'h1,
        OP_STORE= 4'h2,
        OP_MOV  = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_INC  = 4'h6,
        OP_JMP  = 4'h7,
        OP_JZ   = 4'h8,
        OP_JNZ  = 4'h9,
        OP_HALT = 4'hF
    } ctrl_op_e;

    function automatic logic isSelected(input logic wen,
                                        input logic [7:0] busOut,
                                        input logic [7:0] regId);
        return wen && (busOut == regId);
    endfunction

endpackage

// File: rtl/module_reg_f_if.sv
// Register-file write path and readback bundle between the control unit
// (master) and an addressable datapath register (slave).
interface module_reg_f_if
    import module_reg_f_pkg::*;
    ();

    logic       wen;
    logic [7:0] busOut;
    logic       inc;
    data_t      din;
    data_t      dout;
    logic       z;

    modport master (
        output wen,
        output busOut,
        output inc,
        output din,
        input  dout,
        input  z
    );

    modport slave (
        input  wen,
        input  busOut,
        input  inc,
        input  din,
        output dout,
        output z
    );

endinterface

// File: rtl/module_reg_f_inc8.sv
// Plain modulo-2^W incrementer, kept separate so the PC can reuse it.
module module_reg_f_inc8 #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    output logic [W-1:0] o_sum
);

    // Carry out of the top bit is dropped, giving natural wrap to zero
    assign o_sum = i_a + {{(W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/module_reg_f.sv
// Addressable 8-bit general register with self-increment and zero flag.
// A bus write addressed to REG_ID beats an increment; reset clears at once.
module module_reg_f
    import module_reg_f_pkg::*;
#(
    parameter logic [7:0] REG_ID = REG_F_ID
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    module_reg_f_if.slave bus
);

    data_t r_data;
    data_t w_incValue;
    logic  w_sel;

    assign w_sel = isSelected(bus.wen, bus.busOut, REG_ID);

    module_reg_f_inc8 #(
        .W (DATA_W)
    ) u_inc8 (
        .i_a   (r_data),
        .o_sum (w_incValue)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
        end else if (w_sel) begin
            r_data <= bus.din;
        end else if (bus.inc) begin
            r_data <= w_incValue;
        end
    end

    assign bus.dout = r_data;
    assign bus.z    = (r_data == '0);

endmodule

// File: tb/tb_module_reg_f.sv
// Self-checking bench for module_reg_f: directed scenarios followed by a
// randomized run compared against an arithmetic model of the priority rules.
module tb_module_reg_f;

    logic clk = 1'b0;
    logic rstN;
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   modelVal    = 0;

    always #5 clk = ~clk;

    module_reg_f_if busIf();

    module_reg_f #(
        .REG_ID (8'd20)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .bus     (busIf)
    );

    // Inputs change on the falling edge, well away from the sampling edge
    task automatic applyStimulus(input logic wen, input logic [7:0] busOut,
                                 input logic inc, input logic [7:0] din);
        @(negedge clk);
        busIf.wen    = wen;
        busIf.busOut = busOut;
        busIf.inc    = inc;
        busIf.din    = din;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nextValue(input int cur, input logic wen, input logic [7:0] busOut,
                                     input logic inc, input logic [7:0] din);
        if (wen && busOut == 8'd20) return int'(din);
        if (inc) return (cur + 1) % 256;
        return cur;
    endfunction

    task automatic test_reset();
        rstN         = 1'b0;
        busIf.wen    = 1'b1;
        busIf.busOut = 8'd20;
        busIf.inc    = 1'b0;
        busIf.din    = 8'd23;
        #2;
        testsRun++;
        if (busIf.dout !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_dout: got %0d expected 0", busIf.dout);
        end
        testsRun++;
        if (busIf.z !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_z: got %b expected 1", busIf.z);
        end
        tick();
        testsRun++;
        if (busIf.dout !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_edge_dout: got %0d expected 0", busIf.dout);
        end
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_addressed_write();
        applyStimulus(1'b1, 8'd20, 1'b0, 8'd23);
        tick();
        testsRun++;
        if (busIf.dout !== 8'd23) begin
            testsFailed++;
            $display("[TB] FAIL write_dout: got %0d expected 23", busIf.dout);
        end
        testsRun++;
        if (busIf.z !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL write_z: got %b expected 0", busIf.z);
        end
    endtask

    task automatic test_unaddressed_write();
        applyStimulus(1'b1, 8'd24, 1'b0, 8'd99);
        tick();
        testsRun++;
        if (busIf.dout !== 8'd23) begin
            testsFailed++;
            $display("[TB] FAIL unaddressed_dout: got %0d expected 23", busIf.dout);
        end
    endtask

    task automatic test_increment();
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b0, 8'd12, 1'b1, 8'd0);
            tick();
            testsRun++;
            if (busIf.dout !== 8'(23 + i)) begin
                testsFailed++;
                $display("[TB] FAIL inc_step%0d: got %0d expected %0d", i, busIf.dout, 23 + i);
            end
        end
        applyStimulus(1'b1, 8'd21, 1'b1, 8'd77);
        tick();
        testsRun++;
        if (busIf.dout !== 8'd27) begin
            testsFailed++;
            $display("[TB] FAIL unaddressed_with_inc: got %0d expected 27", busIf.dout);
        end
        applyStimulus(1'b0, 8'd20, 1'b0, 8'd5);
        tick();
        testsRun++;
        if (busIf.dout !== 8'd27) begin
            testsFailed++;
            $display("[TB] FAIL hold: got %0d expected 27", busIf.dout);
        end
    endtask

    task automatic test_priority_wrap();
        applyStimulus(1'b1, 8'd20, 1'b1, 8'hFF);
        tick();
        testsRun++;
        if (busIf.dout !== 8'd255) begin
            testsFailed++;
            $display("[TB] FAIL priority_write: got %0d expected 255", busIf.dout);
        end
        applyStimulus(1'b0, 8'd12, 1'b1, 8'd0);
        tick();
        testsRun++;
        if (busIf.dout !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL wrap_dout: got %0d expected 0", busIf.dout);
        end
        testsRun++;
        if (busIf.z !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL wrap_z: got %b expected 1", busIf.z);
        end
    endtask

    task automatic test_async_reset();
        applyStimulus(1'b1, 8'd20, 1'b0, 8'd26);
        tick();
        testsRun++;
        if (busIf.dout !== 8'd26) begin
            testsFailed++;
            $display("[TB] FAIL preload_26: got %0d expected 26", busIf.dout);
        end
        @(negedge clk);
        busIf.wen = 1'b0;
        busIf.inc = 1'b1;
        #1 rstN = 1'b0;
        #1;
        testsRun++;
        if (busIf.dout !== 8'd0 || busIf.z !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL async_clear: got dout=%0d z=%b expected dout=0 z=1", busIf.dout, busIf.z);
        end
        tick();
        testsRun++;
        if (busIf.dout !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL held_in_reset: got %0d expected 0", busIf.dout);
        end
        @(negedge clk);
        rstN = 1'b1;
        tick();
        testsRun++;
        if (busIf.dout !== 8'd1) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_inc: got %0d expected 1", busIf.dout);
        end
        modelVal = 1;
    endtask

    task automatic test_random();
        logic       wen;
        logic       inc;
        logic [7:0] busOut;
        logic [7:0] din;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if ($urandom_range(0, 9) == 0) begin
                rstN = 1'b0;
                #1;
                modelVal = 0;
                testsRun++;
                if (busIf.dout !== 8'd0) begin
                    testsFailed++;
                    $display("[TB] FAIL rand_reset cyc%0d: got %0d expected 0", cyc, busIf.dout);
                end
                #1 rstN = 1'b1;
            end
            wen    = 1'($urandom_range(0, 1));
            inc    = 1'($urandom_range(0, 1));
            busOut = ($urandom_range(0, 1) == 1) ? 8'd20 : 8'($urandom_range(0, 255));
            din    = 8'($urandom_range(0, 255));
            applyStimulus(wen, busOut, inc, din);
            modelVal = nextValue(modelVal, wen, busOut, inc, din);
            tick();
            testsRun++;
            if (busIf.dout !== 8'(modelVal) || busIf.z !== (modelVal == 0)) begin
                testsFailed++;
                $display("[TB] FAIL rand cyc%0d: got dout=%0d z=%b expected dout=%0d z=%b",
                         cyc, busIf.dout, busIf.z, modelVal, (modelVal == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_addressed_write();
        test_unaddressed_write();
        test_increment();
        test_priority_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
